// File: rtl/mem_stage_unit.sv
// mem_stage_unit: EX/MEM and MEM/WB pipeline registers around a busywait data-memory port.
// Handles byte/half/word lanes, load extension and store replication.
// Optional build macro: MISALIGN_TRAP_EN (misaligned accesses are suppressed and flagged via MISALIGN_WB).
module mem_stage_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REG_WRITE_EN_EX,
  input  logic [1:0]        WB_VALUE_SEL_EX,
  input  logic              MEM_READ_EN_EX,
  input  logic              MEM_WRITE_EN_EX,
  input  logic [31:0]       PC_EX,
  input  logic [31:0]       RESULT,
  input  logic [31:0]       REG_DATA_2_EX,
  input  logic [2:0]        FUNC3_EX,
  input  logic [4:0]        REG_WRITE_ADDR_EX,
  input  logic [31:0]       DMEM_READDATA,
  input  logic              DMEM_BUSYWAIT,
  output logic              DMEM_READ,
  output logic              DMEM_WRITE,
  output logic [ADDR_W-1:0] DMEM_ADDR,
  output logic [31:0]       DMEM_WRITEDATA,
  output logic [3:0]        DMEM_BYTE_EN,
  output logic              MEM_BUSYWAIT,
  output logic [31:0]       ALU_RES_MEM,
  output logic [4:0]        REG_WRITE_ADDR_MEM,
  output logic              REG_WRITE_EN_MEM,
  output logic              MEM_WRITE_EN_MEM,
  output logic              REG_WRITE_EN_WB,
  output logic [1:0]        WB_VALUE_SEL_WB,
  output logic [31:0]       ALU_RES_WB,
  output logic [31:0]       LOAD_DATA_WB,
  output logic [31:0]       PC_WB,
  output logic [4:0]        REG_WRITE_ADDR_WB
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              MISALIGN_WB
`endif
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  state_e      state_q, state_d;

  // EX/MEM register
  logic        reg_write_en_mem_q, reg_write_en_mem_d;
  logic [1:0]  wb_sel_mem_q, wb_sel_mem_d;
  logic        mem_read_mem_q, mem_read_mem_d;
  logic        mem_write_mem_q, mem_write_mem_d;
  logic [31:0] pc_mem_q, pc_mem_d;
  logic [31:0] alu_res_mem_q, alu_res_mem_d;
  logic [31:0] store_data_mem_q, store_data_mem_d;
  logic [2:0]  func3_mem_q, func3_mem_d;
  logic [4:0]  rd_mem_q, rd_mem_d;

  // MEM/WB register
  logic        reg_write_en_wb_q, reg_write_en_wb_d;
  logic [1:0]  wb_sel_wb_q, wb_sel_wb_d;
  logic [31:0] alu_res_wb_q, alu_res_wb_d;
  logic [31:0] load_data_wb_q, load_data_wb_d;
  logic [31:0] pc_wb_q, pc_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_wb_q, misalign_wb_d;
  logic        misalign_mem_c;
`endif

  logic        mem_busy_c;
  logic        mem_op_ex_c;
  logic [1:0]  lane_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_ext_c;

`ifdef MISALIGN_TRAP_EN
  // Half needs even address, word needs word-aligned address
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction
`endif

  // Port lanes, store replication and load extraction from the EX/MEM contents
  always_comb begin
    lane_c         = alu_res_mem_q[1:0];
    DMEM_BYTE_EN   = 4'b1111;
    DMEM_WRITEDATA = store_data_mem_q;
    case (func3_mem_q[1:0])
      2'b00: begin
        DMEM_BYTE_EN   = 4'(4'b0001 << lane_c);
        DMEM_WRITEDATA = {4{store_data_mem_q[7:0]}};
      end
      2'b01: begin
        DMEM_BYTE_EN   = lane_c[1] ? 4'b1100 : 4'b0011;
        DMEM_WRITEDATA = {2{store_data_mem_q[15:0]}};
      end
      default: ;
    endcase
    ld_byte_c = 8'(DMEM_READDATA >> {lane_c, 3'b000});
    ld_half_c = lane_c[1] ? DMEM_READDATA[31:16] : DMEM_READDATA[15:0];
    case (func3_mem_q)
      3'b000:  ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b100:  ld_ext_c = {24'd0, ld_byte_c};
      3'b101:  ld_ext_c = {16'd0, ld_half_c};
      default: ld_ext_c = DMEM_READDATA;
    endcase
  end

  // Next-state for FSM, EX/MEM hold/load and MEM/WB load/bubble
  always_comb begin
    mem_busy_c  = (state_q == ACCESS) && DMEM_BUSYWAIT;
`ifdef MISALIGN_TRAP_EN
    mem_op_ex_c = (MEM_READ_EN_EX || MEM_WRITE_EN_EX) && !is_misaligned(FUNC3_EX, RESULT[1:0]);
    misalign_mem_c = (mem_read_mem_q || mem_write_mem_q) && is_misaligned(func3_mem_q, alu_res_mem_q[1:0]);
`else
    mem_op_ex_c = MEM_READ_EN_EX || MEM_WRITE_EN_EX;
`endif

    state_d = IDLE;
    if (mem_busy_c || mem_op_ex_c) state_d = ACCESS;

    reg_write_en_mem_d = reg_write_en_mem_q;
    wb_sel_mem_d       = wb_sel_mem_q;
    mem_read_mem_d     = mem_read_mem_q;
    mem_write_mem_d    = mem_write_mem_q;
    pc_mem_d           = pc_mem_q;
    alu_res_mem_d      = alu_res_mem_q;
    store_data_mem_d   = store_data_mem_q;
    func3_mem_d        = func3_mem_q;
    rd_mem_d           = rd_mem_q;

    reg_write_en_wb_d = 1'b0;
    wb_sel_wb_d       = 2'b00;
    alu_res_wb_d      = 32'd0;
    load_data_wb_d    = 32'd0;
    pc_wb_d           = 32'd0;
    rd_wb_d           = 5'd0;
`ifdef MISALIGN_TRAP_EN
    misalign_wb_d     = 1'b0;
`endif

    if (!mem_busy_c) begin
      reg_write_en_mem_d = REG_WRITE_EN_EX;
      wb_sel_mem_d       = WB_VALUE_SEL_EX;
      mem_read_mem_d     = MEM_READ_EN_EX;
      mem_write_mem_d    = MEM_WRITE_EN_EX;
      pc_mem_d           = PC_EX;
      alu_res_mem_d      = RESULT;
      store_data_mem_d   = REG_DATA_2_EX;
      func3_mem_d        = FUNC3_EX;
      rd_mem_d           = REG_WRITE_ADDR_EX;

      reg_write_en_wb_d = reg_write_en_mem_q;
      wb_sel_wb_d       = wb_sel_mem_q;
      alu_res_wb_d      = alu_res_mem_q;
      pc_wb_d           = pc_mem_q;
      rd_wb_d           = rd_mem_q;
      if (state_q == ACCESS && mem_read_mem_q && !mem_write_mem_q) load_data_wb_d = ld_ext_c;
`ifdef MISALIGN_TRAP_EN
      misalign_wb_d = misalign_mem_c;
      if (misalign_mem_c) reg_write_en_wb_d = 1'b0;
`endif
    end
  end

  // State and pipeline registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q            <= IDLE;
      reg_write_en_mem_q <= 1'b0;
      wb_sel_mem_q       <= 2'b00;
      mem_read_mem_q     <= 1'b0;
      mem_write_mem_q    <= 1'b0;
      pc_mem_q           <= 32'd0;
      alu_res_mem_q      <= 32'd0;
      store_data_mem_q   <= 32'd0;
      func3_mem_q        <= 3'd0;
      rd_mem_q           <= 5'd0;
      reg_write_en_wb_q  <= 1'b0;
      wb_sel_wb_q        <= 2'b00;
      alu_res_wb_q       <= 32'd0;
      load_data_wb_q     <= 32'd0;
      pc_wb_q            <= 32'd0;
      rd_wb_q            <= 5'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_wb_q      <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      reg_write_en_mem_q <= reg_write_en_mem_d;
      wb_sel_mem_q       <= wb_sel_mem_d;
      mem_read_mem_q     <= mem_read_mem_d;
      mem_write_mem_q    <= mem_write_mem_d;
      pc_mem_q           <= pc_mem_d;
      alu_res_mem_q      <= alu_res_mem_d;
      store_data_mem_q   <= store_data_mem_d;
      func3_mem_q        <= func3_mem_d;
      rd_mem_q           <= rd_mem_d;
      reg_write_en_wb_q  <= reg_write_en_wb_d;
      wb_sel_wb_q        <= wb_sel_wb_d;
      alu_res_wb_q       <= alu_res_wb_d;
      load_data_wb_q     <= load_data_wb_d;
      pc_wb_q            <= pc_wb_d;
      rd_wb_q            <= rd_wb_d;
`ifdef MISALIGN_TRAP_EN
      misalign_wb_q      <= misalign_wb_d;
`endif
    end
  end

  // Strobes follow the registered enables only while a transaction is open
  assign DMEM_READ          = (state_q == ACCESS) && mem_read_mem_q && !mem_write_mem_q;
  assign DMEM_WRITE         = (state_q == ACCESS) && mem_write_mem_q;
  assign DMEM_ADDR          = {alu_res_mem_q[ADDR_W-1:2], 2'b00};
  assign MEM_BUSYWAIT       = mem_busy_c;
  assign ALU_RES_MEM        = alu_res_mem_q;
  assign REG_WRITE_ADDR_MEM = rd_mem_q;
  assign REG_WRITE_EN_MEM   = reg_write_en_mem_q;
  assign MEM_WRITE_EN_MEM   = mem_write_mem_q;
  assign REG_WRITE_EN_WB    = reg_write_en_wb_q;
  assign WB_VALUE_SEL_WB    = wb_sel_wb_q;
  assign ALU_RES_WB         = alu_res_wb_q;
  assign LOAD_DATA_WB       = load_data_wb_q;
  assign PC_WB              = pc_wb_q;
  assign REG_WRITE_ADDR_WB  = rd_wb_q;
`ifdef MISALIGN_TRAP_EN
  assign MISALIGN_WB        = misalign_wb_q;
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: loads, stores, stalls, back-to-back and reset.
module tb_mem_stage_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        REG_WRITE_EN_EX;
  logic [1:0]  WB_VALUE_SEL_EX;
  logic        MEM_READ_EN_EX;
  logic        MEM_WRITE_EN_EX;
  logic [31:0] PC_EX;
  logic [31:0] RESULT;
  logic [31:0] REG_DATA_2_EX;
  logic [2:0]  FUNC3_EX;
  logic [4:0]  REG_WRITE_ADDR_EX;
  logic [31:0] DMEM_READDATA;
  logic        DMEM_BUSYWAIT;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WRITEDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        MEM_BUSYWAIT;
  logic [31:0] ALU_RES_MEM;
  logic [4:0]  REG_WRITE_ADDR_MEM;
  logic        REG_WRITE_EN_MEM;
  logic        MEM_WRITE_EN_MEM;
  logic        REG_WRITE_EN_WB;
  logic [1:0]  WB_VALUE_SEL_WB;
  logic [31:0] ALU_RES_WB;
  logic [31:0] LOAD_DATA_WB;
  logic [31:0] PC_WB;
  logic [4:0]  REG_WRITE_ADDR_WB;
`ifdef MISALIGN_TRAP_EN
  logic        MISALIGN_WB;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_stage_unit #(.ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .REG_WRITE_EN_EX(REG_WRITE_EN_EX), .WB_VALUE_SEL_EX(WB_VALUE_SEL_EX),
    .MEM_READ_EN_EX(MEM_READ_EN_EX), .MEM_WRITE_EN_EX(MEM_WRITE_EN_EX),
    .PC_EX(PC_EX), .RESULT(RESULT), .REG_DATA_2_EX(REG_DATA_2_EX),
    .FUNC3_EX(FUNC3_EX), .REG_WRITE_ADDR_EX(REG_WRITE_ADDR_EX),
    .DMEM_READDATA(DMEM_READDATA), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .DMEM_READ(DMEM_READ), .DMEM_WRITE(DMEM_WRITE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WRITEDATA(DMEM_WRITEDATA), .DMEM_BYTE_EN(DMEM_BYTE_EN),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .ALU_RES_MEM(ALU_RES_MEM), .REG_WRITE_ADDR_MEM(REG_WRITE_ADDR_MEM),
    .REG_WRITE_EN_MEM(REG_WRITE_EN_MEM), .MEM_WRITE_EN_MEM(MEM_WRITE_EN_MEM),
    .REG_WRITE_EN_WB(REG_WRITE_EN_WB), .WB_VALUE_SEL_WB(WB_VALUE_SEL_WB),
    .ALU_RES_WB(ALU_RES_WB), .LOAD_DATA_WB(LOAD_DATA_WB), .PC_WB(PC_WB),
    .REG_WRITE_ADDR_WB(REG_WRITE_ADDR_WB)
`ifdef MISALIGN_TRAP_EN
    , .MISALIGN_WB(MISALIGN_WB)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] sel, input logic rd, input logic wr,
                       input logic [31:0] pc, input logic [31:0] res, input logic [31:0] sd,
                       input logic [2:0] f3, input logic [4:0] rdst);
    REG_WRITE_EN_EX = we;  WB_VALUE_SEL_EX = sel;
    MEM_READ_EN_EX = rd;   MEM_WRITE_EN_EX = wr;
    PC_EX = pc;  RESULT = res;  REG_DATA_2_EX = sd;
    FUNC3_EX = f3;  REG_WRITE_ADDR_EX = rdst;
  endtask

  task automatic nop();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 3'd0, 5'd0);
  endtask

  // Issue a single load with no busy cycles and check the extended writeback value
  task automatic load_once(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [3:0] be, input logic [31:0] exp);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h300, addr, 32'd0, f3, 5'd9);
    DMEM_READDATA = rdata;
    DMEM_BUSYWAIT = 1'b0;
    step();
    nop();
    #1;
    check({tag, "_be"}, 32'(DMEM_BYTE_EN), 32'(be));
    check({tag, "_rd"}, 32'(DMEM_READ), 32'd1);
    step();
    check({tag, "_data"}, LOAD_DATA_WB, exp);
  endtask

  int busy_cnt;
  int wb_pulses;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  initial begin
    RESET = 1'b0;
    nop();
    DMEM_READDATA = 32'd0;
    DMEM_BUSYWAIT = 1'b0;
    step();
    step();
    check("rst_read", 32'(DMEM_READ), 32'd0);
    check("rst_busy", 32'(MEM_BUSYWAIT), 32'd0);
    check("rst_alu_wb", ALU_RES_WB, 32'd0);
    check("rst_we_wb", 32'(REG_WRITE_EN_WB), 32'd0);
    RESET = 1'b1;
    step();

    // Non-memory op: two edges to writeback
    drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h80, 32'h55, 32'd0, 3'd0, 5'd7);
    step();
    nop();
    #1;
    check("alu_mem", ALU_RES_MEM, 32'h55);
    check("alu_rd_mem", 32'(REG_WRITE_ADDR_MEM), 32'd7);
    check("alu_no_strobe", 32'({DMEM_READ, DMEM_WRITE}), 32'd0);
    step();
    check("alu_wb", ALU_RES_WB, 32'h55);
    check("alu_pc_wb", PC_WB, 32'h80);
    check("alu_we_wb", 32'(REG_WRITE_EN_WB), 32'd1);

    // LW 0x104 with three busy cycles
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h100, 32'h104, 32'd0, 3'b010, 5'd5);
    DMEM_READDATA = 32'hDEADBEEF;
    DMEM_BUSYWAIT = 1'b1;
    step();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h104, 32'h999, 32'd0, 3'd0, 5'd0);
    #1;
    check("lw_addr", DMEM_ADDR, 32'h104);
    check("lw_read", 32'(DMEM_READ), 32'd1);
    busy_cnt = 0;
    wb_pulses = 0;
    wb_data = 32'd0;
    wb_rd = 5'd0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 3) DMEM_BUSYWAIT = 1'b0;
      #1;
      if (cyc == 2) check("lw_hold", ALU_RES_MEM, 32'h104);
      if (MEM_BUSYWAIT) busy_cnt++;
      if (REG_WRITE_EN_WB) begin
        wb_pulses++;
        wb_data = LOAD_DATA_WB;
        wb_rd = REG_WRITE_ADDR_WB;
      end
      if (cyc == 4) nop();
      step();
    end
    check("lw_busy_cycles", 32'(busy_cnt), 32'd3);
    check("lw_wb_pulses", 32'(wb_pulses), 32'd1);
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_rd", 32'(wb_rd), 32'd5);
    check("lw_read_done", 32'(DMEM_READ), 32'd0);

    // Sub-word loads from lane 3 / upper half
    load_once("lb", 32'h203, 3'b000, 32'h80112233, 4'b1000, 32'hFFFFFF80);
    load_once("lbu", 32'h203, 3'b100, 32'h80112233, 4'b1000, 32'h00000080);
    load_once("lh", 32'h202, 3'b001, 32'h80112233, 4'b1100, 32'hFFFF8011);
    load_once("lhu", 32'h202, 3'b101, 32'h80112233, 4'b1100, 32'h00008011);
    load_once("lb0", 32'h200, 3'b000, 32'h80112233, 4'b0001, 32'h00000033);

    // SH 0x12 with two busy cycles
    drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h400, 32'h12, 32'h0000ABCD, 3'b001, 5'd0);
    DMEM_BUSYWAIT = 1'b1;
    step();
    nop();
    #1;
    check("sh_be", 32'(DMEM_BYTE_EN), 32'hC);
    check("sh_wdata", DMEM_WRITEDATA, 32'hABCDABCD);
    check("sh_addr", DMEM_ADDR, 32'h10);
    check("sh_we_mem", 32'(MEM_WRITE_EN_MEM), 32'd1);
    step();
    check("sh_write_held", 32'(DMEM_WRITE), 32'd1);
    check("sh_busy", 32'(MEM_BUSYWAIT), 32'd1);
    DMEM_BUSYWAIT = 1'b0;
    step();
    check("sh_write_done", 32'(DMEM_WRITE), 32'd0);

    // SB lane replication
    drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h404, 32'h41, 32'h123456A5, 3'b000, 5'd0);
    step();
    nop();
    #1;
    check("sb_be", 32'(DMEM_BYTE_EN), 32'h2);
    check("sb_wdata", DMEM_WRITEDATA, 32'hA5A5A5A5);
    step();

    // Read and write both set behaves as a store
    drive(1'b0, 2'b00, 1'b1, 1'b1, 32'h408, 32'h48, 32'h77, 3'b010, 5'd0);
    step();
    nop();
    #1;
    check("rw_strobes", 32'({DMEM_READ, DMEM_WRITE}), 32'd1);
    step();

    // Back-to-back SW 0x40 then LW 0x44
    drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h500, 32'h40, 32'h11223344, 3'b010, 5'd0);
    step();
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h504, 32'h44, 32'd0, 3'b010, 5'd3);
    DMEM_READDATA = 32'hCAFEF00D;
    #1;
    check("b2b_sw_write", 32'(DMEM_WRITE), 32'd1);
    check("b2b_sw_addr", DMEM_ADDR, 32'h40);
    check("b2b_sw_data", DMEM_WRITEDATA, 32'h11223344);
    check("b2b_sw_nostall", 32'(MEM_BUSYWAIT), 32'd0);
    step();
    nop();
    #1;
    check("b2b_lw_strobes", 32'({DMEM_READ, DMEM_WRITE}), 32'd2);
    check("b2b_lw_addr", DMEM_ADDR, 32'h44);
    check("b2b_lw_nostall", 32'(MEM_BUSYWAIT), 32'd0);
    step();
    check("b2b_lw_data", LOAD_DATA_WB, 32'hCAFEF00D);
    check("b2b_lw_rd", 32'(REG_WRITE_ADDR_WB), 32'd3);
    check("b2b_idle", 32'(DMEM_READ), 32'd0);

    // Reset while an access is stalled
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h600, 32'h80, 32'd0, 3'b010, 5'd4);
    DMEM_BUSYWAIT = 1'b1;
    step();
    nop();
    #1;
    check("rstacc_busy", 32'(MEM_BUSYWAIT), 32'd1);
    RESET = 1'b0;
    step();
    check("rstacc_read", 32'(DMEM_READ), 32'd0);
    check("rstacc_busy0", 32'(MEM_BUSYWAIT), 32'd0);
    check("rstacc_we_wb", 32'(REG_WRITE_EN_WB), 32'd0);
    check("rstacc_pc_wb", PC_WB, 32'd0);
    check("rstacc_alu_mem", ALU_RES_MEM, 32'd0);
    RESET = 1'b1;
    DMEM_BUSYWAIT = 1'b0;
    step();

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load is trapped
    drive(1'b1, 2'b01, 1'b1, 1'b0, 32'h700, 32'h102, 32'd0, 3'b010, 5'd6);
    DMEM_BUSYWAIT = 1'b1;
    step();
    nop();
    #1;
    check("mis_strobes", 32'({DMEM_READ, DMEM_WRITE}), 32'd0);
    check("mis_busy", 32'(MEM_BUSYWAIT), 32'd0);
    step();
    check("mis_flag", 32'(MISALIGN_WB), 32'd1);
    check("mis_we_wb", 32'(REG_WRITE_EN_WB), 32'd0);
    DMEM_BUSYWAIT = 1'b0;
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
